// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: VGA receive-side checker.
// Registers hsync/vsync/color once and rebuilds column/row coordinates from them.
// Checks the line period and frame length, and locks after LOCK_FRAMES good frames.
// While locked, it produces a CRC-16-CCITT over the active pixels of each frame.
// Optional build macro VGA_RX_STATS_EN adds two outputs:
//   err_count    - saturating count of sync errors
//   h_total_meas - last measured line period
module vga_rx_monitor #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [5:0]  color_in,
  output logic [9:0]  col_out,
  output logic [9:0]  row_out,
  output logic [5:0]  color_out,
  output logic        pixel_valid,
  output logic        locked,
  output logic        sync_err,
  output logic        frame_done,
  output logic [15:0] frame_crc
`ifdef VGA_RX_STATS_EN
  ,
  output logic [7:0]  err_count,
  output logic [10:0] h_total_meas
`endif
);

  localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
  localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
  localparam int GW      = $clog2(LOCK_FRAMES + 1);
  localparam logic        POL       = (SYNC_ACTIVE_LOW != 0);
  localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [10:0] H_START_W = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END_W   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_START_W = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END_W   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [GW-1:0] LOCK_W  = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  logic          r_hs_s1, r_vs_s1, r_hs_s2, r_vs_s2;
  logic [5:0]    r_color_s1;
  logic [10:0]   r_hcnt;
  logic [9:0]    r_vcnt;
  logic          r_after_v;
  state_t        r_state;
  logic [GW-1:0] r_good;
  logic          r_frame_full;
  logic [15:0]   r_crc;
  logic [9:0]    r_col, r_row;
  logic [5:0]    r_color;
  logic          r_pv, r_err, r_done;
  logic [15:0]   r_fcrc;

  logic          w_h_edge, w_v_edge, w_hcnt_sat, w_vcnt_sat;
  logic [10:0]   w_hpos;
  logic [9:0]    w_vpos;
  logic [11:0]   w_h_len;
  logic [10:0]   w_lines;
  logic          w_h_skip, w_h_bad, w_v_bad, w_active, w_pv;
  logic [15:0]   w_crc_next;
  state_t        w_st_h, w_state_next;
  logic [GW-1:0] w_good_next, w_good_inc;
  logic          w_err, w_done, w_full_next;

  // One byte of CRC-16-CCITT (poly 0x1021), MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // Edges are transitions into the asserted state.
  // Position signals describe the sample currently held in s1.
  assign w_h_edge   = r_hs_s1 & ~r_hs_s2;
  assign w_v_edge   = r_vs_s1 & ~r_vs_s2;
  assign w_hcnt_sat = &r_hcnt;
  assign w_vcnt_sat = &r_vcnt;
  assign w_hpos     = w_h_edge ? 11'd0 : (w_hcnt_sat ? r_hcnt : r_hcnt + 11'd1);
  assign w_vpos     = w_v_edge ? 10'd0 :
                      ((w_h_edge && !w_vcnt_sat) ? r_vcnt + 10'd1 : r_vcnt);
  assign w_h_len    = {1'b0, r_hcnt} + 12'd1;
  assign w_lines    = {1'b0, r_vcnt} + {10'd0, w_h_edge};
  // A saturated count right after vsync means no reference line yet; skip it.
  assign w_h_skip   = w_hcnt_sat & (r_after_v | w_v_edge);
  assign w_h_bad    = w_h_edge & ~w_h_skip & (w_h_len != H_TOTAL_W);
  assign w_v_bad    = w_v_edge & (w_lines != V_TOTAL_W);
  assign w_active   = (w_hpos >= H_START_W) && (w_hpos < H_END_W) &&
                      (w_vpos >= V_START_W) && (w_vpos < V_END_W);
  assign w_pv       = w_active && (r_state == ST_LOCKED);
  assign w_crc_next = crc16_byte(r_crc, {2'b00, r_color_s1});
  assign w_good_inc = r_good + GW'(1);
  // The hsync check is resolved first; the vsync check sees its outcome.
  assign w_st_h     = (r_state != ST_SEARCH && w_h_bad) ? ST_SEARCH : r_state;

  // Next-state logic: lock qualification, error pulse and frame-done decision.
  always_comb begin
    w_state_next = w_st_h;
    w_good_next  = r_good;
    w_err        = (r_state != ST_SEARCH) && w_h_bad;
    w_done       = 1'b0;
    w_full_next  = r_frame_full;
    if (w_v_edge) begin
      case (w_st_h)
        ST_SEARCH: begin
          w_state_next = ST_MEASURE;
          w_good_next  = '0;
        end
        ST_MEASURE: begin
          if (w_v_bad) begin
            w_state_next = ST_SEARCH;
            w_err        = 1'b1;
          end else begin
            w_good_next = w_good_inc;
            if (w_good_inc == LOCK_W) w_state_next = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_v_bad) begin
            w_state_next = ST_SEARCH;
            w_err        = 1'b1;
          end else if (r_frame_full) begin
            w_done = 1'b1;
          end
        end
        default: w_state_next = ST_SEARCH;
      endcase
      // A frame is fully accumulated only if it starts in the locked state.
      w_full_next = (w_state_next == ST_LOCKED);
    end
  end

  // Input stage: s1 samples the pins (sync normalised to active-high); s2 keeps s1 for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_s1    <= 1'b0;
      r_vs_s1    <= 1'b0;
      r_hs_s2    <= 1'b0;
      r_vs_s2    <= 1'b0;
      r_color_s1 <= 6'd0;
    end else begin
      r_hs_s1    <= hsync_in ^ POL;
      r_vs_s1    <= vsync_in ^ POL;
      r_hs_s2    <= r_hs_s1;
      r_vs_s2    <= r_vs_s1;
      r_color_s1 <= color_in;
    end
  end

  // Horizontal/vertical position counters and the "first hsync after vsync" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt    <= 11'd0;
      r_vcnt    <= 10'd0;
      r_after_v <= 1'b0;
    end else begin
      r_hcnt    <= w_hpos;
      r_vcnt    <= w_vpos;
      r_after_v <= w_v_edge ? ~w_h_edge : (w_h_edge ? 1'b0 : r_after_v);
    end
  end

  // Lock state register, good-frame counter and full-frame flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SEARCH;
      r_good       <= '0;
      r_frame_full <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_good       <= w_good_next;
      r_frame_full <= w_full_next;
    end
  end

  // Per-frame CRC accumulator: restarts at every vsync edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 16'hFFFF;
    end else if (w_v_edge) begin
      r_crc <= 16'hFFFF;
    end else if (w_pv) begin
      r_crc <= w_crc_next;
    end
  end

  // Output registers: coordinates hold outside the active area.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= 10'd0;
      r_row   <= 10'd0;
      r_color <= 6'd0;
      r_pv    <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_fcrc  <= 16'd0;
    end else begin
      if (w_active) begin
        r_col <= 10'(w_hpos - H_START_W);
        r_row <= w_vpos - V_START_W;
      end
      r_color <= r_color_s1;
      r_pv    <= w_pv;
      r_err   <= w_err;
      r_done  <= w_done;
      if (w_done) r_fcrc <= r_crc;
    end
  end

  assign col_out     = r_col;
  assign row_out     = r_row;
  assign color_out   = r_color;
  assign pixel_valid = r_pv;
  assign locked      = (r_state == ST_LOCKED);
  assign sync_err    = r_err;
  assign frame_done  = r_done;
  assign frame_crc   = r_fcrc;

`ifdef VGA_RX_STATS_EN
  logic [7:0]  r_err_cnt;
  logic [10:0] r_h_meas;

  // Saturating error counter and last measured line period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
      r_h_meas  <= 11'd0;
    end else begin
      if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_h_edge) r_h_meas <= w_h_len[11] ? 11'h7FF : w_h_len[10:0];
    end
  end

  assign err_count    = r_err_cnt;
  assign h_total_meas = r_h_meas;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed bench for vga_rx_monitor.
// Uses a reduced 16x9 raster (8x4 active) so whole frames are short.
// Build macro VGA_RX_STATS_EN enables the statistics checks.
module tb_vga_rx_monitor;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 16
  localparam int VT = VA + VF + VS + VB;   // 9

  logic        clk, rst_n, hsync_in, vsync_in;
  logic [5:0]  color_in;
  logic [9:0]  col_out, row_out;
  logic [5:0]  color_out;
  logic        pixel_valid, locked, sync_err, frame_done;
  logic [15:0] frame_crc;
`ifdef VGA_RX_STATS_EN
  logic [7:0]  err_count;
  logic [10:0] h_total_meas;
`endif

  vga_rx_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .color_in(color_in), .col_out(col_out), .row_out(row_out),
    .color_out(color_out), .pixel_valid(pixel_valid), .locked(locked),
    .sync_err(sync_err), .frame_done(frame_done), .frame_crc(frame_crc)
`ifdef VGA_RX_STATS_EN
    , .err_count(err_count), .h_total_meas(h_total_meas)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Observation state gathered on the falling edge.
  int n_pv = 0, n_err = 0, n_done = 0, done_run = 0, max_run = 0;
  int first_pv_cyc = -1, lock_cyc = -1;
  logic pv_seen = 1'b0, prev_locked = 1'b0, err_locked = 1'b1, err_prev_locked = 1'b0;
  logic [9:0] first_col = '1, first_row = '1, last_col = '0, last_row = '0;
  logic [5:0] first_color = '0;
  int err_hmeas = 0;
  int v_cyc = 0, act0_cyc = 0;

  always @(negedge clk) begin
    if (pixel_valid) begin
      n_pv++;
      if (!pv_seen) begin
        pv_seen      = 1'b1;
        first_pv_cyc = cyc;
        first_col    = col_out;
        first_row    = row_out;
        first_color  = color_out;
      end
      last_col = col_out;
      last_row = row_out;
    end
    if (sync_err) begin
      n_err++;
      err_locked      = locked;
      err_prev_locked = prev_locked;
`ifdef VGA_RX_STATS_EN
      err_hmeas = int'(h_total_meas);
`endif
    end
    if (frame_done) begin
      n_done++;
      done_run++;
      if (done_run > max_run) max_run = done_run;
    end else begin
      done_run = 0;
    end
    if (locked && !prev_locked) lock_cyc = cyc;
    prev_locked = locked;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_rep(input logic [7:0] b, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ b[i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // Drive one pixel-clock slot of the raster (sync pulses are low-true).
  task automatic drive(input int line, input int pos, input logic [5:0] c);
    logic hs, vs, act;
    hs  = (pos < HS);
    vs  = (line < VS);
    act = (pos >= HS + HB) && (pos < HS + HB + HA) && (line >= VS + VB) && (line < VS + VB + VA);
    hsync_in = ~hs;
    vsync_in = ~vs;
    color_in = act ? c : 6'h00;
    if (line == 0 && pos == 0) v_cyc = cyc;
    if (line == VS + VB && pos == HS + HB) act0_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int nlines, input int stretch, input logic [5:0] c);
    for (int l = 0; l < nlines; l++)
      for (int p = 0; p < ((l == stretch) ? HT + 1 : HT); p++)
        drive(l, p, c);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; color_in = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", 32'(col_out), 0);
    chk("rst_row", 32'(row_out), 0);
    chk("rst_color", 32'(color_out), 0);
    chk("rst_pv", 32'(pixel_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_crc", 32'(frame_crc), 0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Lock sequence: vsync edges 1 and 2 qualify, edge 3 locks.
    send_frame(VT, -1, 6'h15);
    send_frame(VT, -1, 6'h15);
    chk("locked_before_3rd_vsync", 32'(locked), 0);
    chk("no_err_during_lock", 32'(n_err), 0);
    send_frame(VT, -1, 6'h15);
    $display("frame3: locked=%0d pv=%0d first=(%0d,%0d,%0h)", locked, n_pv, first_col, first_row, first_color);
    chk("locked_after_3rd_vsync", 32'(locked), 1);
    chk("lock_latency", 32'(lock_cyc - v_cyc), 2);
    chk("pv_count_frame3", 32'(n_pv), HA * VA);
    chk("first_col", 32'(first_col), 0);
    chk("first_row", 32'(first_row), 0);
    chk("first_color", 32'(first_color), 6'h15);
    chk("first_pv_latency", 32'(first_pv_cyc - act0_cyc), 2);
    chk("last_col", 32'(last_col), HA - 1);
    chk("last_row", 32'(last_row), VA - 1);
    chk("hold_col", 32'(col_out), HA - 1);
    chk("hold_row", 32'(row_out), VA - 1);
    chk("pv_low_in_porch", 32'(pixel_valid), 0);
    chk("no_done_at_lock", 32'(n_done), 0);

    send_frame(VT, -1, 6'h00);
    $display("frame4: done=%0d crc=%04h", n_done, frame_crc);
    chk("done_count_f3", 32'(n_done), 1);
    chk("crc_frame_15", 32'(frame_crc), 32'(crc_rep(8'h15, HA * VA)));
    send_frame(VT, -1, 6'h00);
    $display("frame5: done=%0d crc=%04h", n_done, frame_crc);
    chk("done_count_f4", 32'(n_done), 2);
    chk("crc_frame_zero", 32'(frame_crc), 32'(crc_rep(8'h00, HA * VA)));
    chk("pv_count_3frames", 32'(n_pv), 3 * HA * VA);
    chk("done_pulse_width", 32'(max_run), 1);

    // Stretched line while locked.
    send_frame(VT, 5, 6'h2A);
    $display("frame6 stretched: err=%0d locked=%0d", n_err, locked);
    chk("stretch_err_count", 32'(n_err), 1);
    chk("stretch_locked_at_err", 32'(err_locked), 0);
    chk("stretch_locked_before_err", 32'(err_prev_locked), 1);
    chk("stretch_locked_after", 32'(locked), 0);
    chk("done_f5", 32'(n_done), 3);
`ifdef VGA_RX_STATS_EN
    chk("h_total_meas_stretch", 32'(err_hmeas), HT + 1);
`endif
    send_frame(VT, -1, 6'h2A);
    chk("no_done_stretched_frame", 32'(n_done), 3);
    send_frame(VT, -1, 6'h3F);
    chk("relock_not_yet", 32'(locked), 0);
    send_frame(VT, -1, 6'h3F);
    chk("relock_after_stretch", 32'(locked), 1);

    // Short frame while locked.
    send_frame(VT - 1, -1, 6'h3F);
    chk("done_f9", 32'(n_done), 4);
    chk("crc_frame_3f", 32'(frame_crc), 32'(crc_rep(8'h3F, HA * VA)));
    send_frame(VT, -1, 6'h01);
    $display("short frame: err=%0d locked=%0d crc=%04h", n_err, locked, frame_crc);
    chk("short_err_count", 32'(n_err), 2);
    chk("short_locked", 32'(locked), 0);
    chk("short_no_done", 32'(n_done), 4);
    chk("short_crc_unchanged", 32'(frame_crc), 32'(crc_rep(8'h3F, HA * VA)));
    send_frame(VT, -1, 6'h01);
    send_frame(VT, -1, 6'h01);
    chk("short_relock_not_yet", 32'(locked), 0);
    send_frame(VT, -1, 6'h01);
    chk("short_relock", 32'(locked), 1);
    chk("short_no_extra_err", 32'(n_err), 2);

    // Asynchronous reset in the middle of an active line.
    for (int l = 0; l < 5; l++)
      for (int p = 0; p < HT; p++) drive(l, p, 6'h0A);
    for (int p = 0; p < 8; p++) drive(5, p, 6'h0A);
    rst_n = 1'b0;
    #1;
    $display("mid-line reset: locked=%0d pv=%0d col=%0d row=%0d crc=%04h", locked, pixel_valid, col_out, row_out, frame_crc);
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_pv", 32'(pixel_valid), 0);
    chk("mid_rst_col", 32'(col_out), 0);
    chk("mid_rst_row", 32'(row_out), 0);
    chk("mid_rst_color", 32'(color_out), 0);
    chk("mid_rst_crc", 32'(frame_crc), 0);
    for (int p = 8; p < 11; p++) drive(5, p, 6'h0A);
    rst_n = 1'b1;
    for (int p = 11; p < HT; p++) drive(5, p, 6'h0A);
    for (int l = 6; l < VT; l++)
      for (int p = 0; p < HT; p++) drive(l, p, 6'h0A);
    send_frame(VT, -1, 6'h0A);
    send_frame(VT, -1, 6'h0A);
    chk("post_rst_not_locked", 32'(locked), 0);
    send_frame(VT, -1, 6'h0A);
    chk("post_rst_locked", 32'(locked), 1);
    chk("post_rst_lock_latency", 32'(lock_cyc - v_cyc), 2);
    chk("post_rst_no_err", 32'(n_err), 2);

`ifdef VGA_RX_STATS_EN
    // 300 line-period errors: each vsync edge re-arms checking, then a 17-clock line fails.
    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < HT; p++) drive(0, p, 6'h00);
      for (int p = 0; p < HT + 1; p++) drive(2, p, 6'h00);
    end
    for (int p = 0; p < HT; p++) drive(0, p, 6'h00);
    $display("stats: err_count=%0d h_total_meas=%0d", err_count, h_total_meas);
    chk("err_count_saturated", 32'(err_count), 255);
    chk("h_total_meas_last", 32'(h_total_meas), HT + 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
